// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV and DIVU.
// Uses 32-step shift-add multiply or restoring divide, then sign fix-up, and stalls dependent readers.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             MfRead,
   input  logic             Abort,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic             Stall
);

   // state | meaning
   // IDLE  | waiting for Start, Hi/Lo final
   // CALC  | one multiply/divide step per cycle, WIDTH cycles
   // FIX   | sign correction, Hi/Lo written on exit
   // DONE  | one-cycle result pulse, may accept the next Start
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam int CW = $clog2(WIDTH);

   state_t             state, state_nxt;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   opb;
   logic               is_div, div_zero, neg_p, neg_r;

   logic               accept, last_step, start_dz, is_signed;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     add_sum, shifted, diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign accept    = (state == IDLE || state == DONE) && Start && !Abort;
   assign last_step = (count == CW'(WIDTH - 1));
   assign start_dz  = Op[1] && (B == '0);
   assign is_signed = !Op[0];
   assign mag_a     = (is_signed && A[WIDTH-1]) ? -A : A;
   assign mag_b     = (is_signed && B[WIDTH-1]) ? -B : B;

   // acc holds {partial product, remaining multiplier} for multiply, and the quotient/dividend in its low half for divide
   assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
   assign shifted  = {rem[WIDTH-1:0], acc[WIDTH-1]};
   assign diff     = shifted - {1'b0, opb};

   assign prod_fix = neg_p ? -acc : acc;
   assign quot_fix = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

   always_comb begin
      state_nxt = state;
      if (Abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, DONE: state_nxt = Start ? (start_dz ? FIX : CALC) : IDLE;
            CALC:       if (last_step) state_nxt = FIX;
            FIX:        state_nxt = DONE;
            default:    state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state    <= IDLE;
         count    <= '0;
         acc      <= '0;
         rem      <= '0;
         opb      <= '0;
         is_div   <= 1'b0;
         div_zero <= 1'b0;
         neg_p    <= 1'b0;
         neg_r    <= 1'b0;
         Hi       <= '0;
         Lo       <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            count    <= '0;
            rem      <= '0;
            is_div   <= Op[1];
            div_zero <= start_dz;
            neg_p    <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r    <= is_signed && A[WIDTH-1];
            if (Op[1]) begin
               // divide by zero returns the raw dividend in Hi
               acc <= {{WIDTH{1'b0}}, (start_dz ? A : mag_a)};
               opb <= mag_b;
            end else begin
               acc <= {{WIDTH{1'b0}}, mag_b};
               opb <= mag_a;
            end
         end else if (state == CALC && !Abort) begin
            count <= count + CW'(1);
            if (is_div) begin
               if (!diff[WIDTH]) begin
                  rem             <= diff;
                  acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b1};
               end else begin
                  rem             <= shifted;
                  acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc <= {add_sum, acc[WIDTH-1:1]};
            end
         end
         if (state == FIX && !Abort) begin
            if (div_zero) begin
               Hi <= acc[WIDTH-1:0];
               Lo <= '1;
            end else if (is_div) begin
               Hi <= rem_fix;
               Lo <= quot_fix;
            end else begin
               {Hi, Lo} <= prod_fix;
            end
         end
      end
   end

   assign Busy      = (state == CALC) || (state == FIX);
   assign Done      = (state == DONE);
   assign DivByZero = Done && div_zero;
   assign Stall     = Busy && (MfRead || Start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected Hi/Lo, a monitor pops on Done.
module tb_muldiv_sequencer;
   localparam int W = 32;

   logic         Clk = 1'b0;
   logic         Rst = 1'b0;
   logic         Start = 1'b0;
   logic [1:0]   Op = 2'b00;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         MfRead = 1'b0;
   logic         Abort = 1'b0;
   logic [W-1:0] Hi, Lo;
   logic         Busy, Done, DivByZero, Stall;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
      .MfRead(MfRead), .Abort(Abort), .Hi(Hi), .Lo(Lo), .Busy(Busy),
      .Done(Done), .DivByZero(DivByZero), .Stall(Stall)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   int           total = 0;
   int           bad = 0;
   logic [W-1:0] old_hi = '0;
   logic [W-1:0] old_lo = '0;

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (Done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got Done=1 expected no pending op");
         end else begin
            mon_e = sb.pop_front();
            check("result_hi", Hi, mon_e.hi);
            check("result_lo", Lo, mon_e.lo);
            check("div_by_zero", DivByZero, mon_e.dbz);
         end
      end else if (DivByZero) begin
         check("dbz_without_done", DivByZero, 0);
      end
   end

   // Drives Start for one edge (E0), then scrambles Op/A/B to show they are ignored after E0.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz);
      exp_t e;
      Op = op; A = a; B = b; Start = 1'b1;
      if (push) begin
         e.hi = hi; e.lo = lo; e.dbz = dbz;
         sb.push_back(e);
      end
      @(posedge Clk); #1;
      Start = 1'b0;
      Op = ~op; A = ~a; B = ~b;
   endtask

   task automatic wait_done(input string name, input int exp_lat);
      int  lat = 0;
      int  busy_n;
      bit  got = 0;
      busy_n = Busy ? 1 : 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(posedge Clk); #1;
         lat++;
         if (Done) got = 1;
         else if (Busy) busy_n++;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no Done after %0d cycles expected Done", name, lat);
      end else begin
         check({name, "_latency"}, lat, exp_lat);
         check({name, "_busy_cycles"}, busy_n, exp_lat);
      end
   endtask

   task automatic run(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz, input int lat);
      repeat (2) @(negedge Clk);
      issue(op, a, b, 1'b1, hi, lo, dbz);
      wait_done(name, lat);
      old_hi = hi;
      old_lo = lo;
   endtask

   initial begin
      int stall_n;
      int done_n;
      repeat (2) @(posedge Clk);
      #1;
      check("reset_hi", Hi, 0);
      check("reset_lo", Lo, 0);
      check("reset_busy", Busy, 0);
      check("reset_done", Done, 0);
      check("reset_dbz", DivByZero, 0);
      Rst = 1'b1;

      run("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
      run("mult_neg",  MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
      run("div_neg",   DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
      run("divu",      DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33);
      run("div_zero",  DIV,   32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1);
      run("div_wrap",  DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33);

      // MfRead stall while busy, old Hi/Lo visible, then back-to-back start from DONE
      repeat (2) @(negedge Clk);
      issue(MULT, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h1, 32'h0, 1'b0);
      repeat (5) begin @(posedge Clk); #1; end
      MfRead  = 1'b1;
      stall_n = 0;
      for (int k = 5; k <= 32; k++) begin
         #1;
         if (Stall) stall_n++;
         if (k == 32) begin
            check("hold_hi_busy", Hi, old_hi);
            check("hold_lo_busy", Lo, old_lo);
         end
         @(posedge Clk); #1;
      end
      #1;
      check("stall_cycles", stall_n, 28);
      check("done_at_e33", Done, 1);
      check("no_stall_in_done", Stall, 0);
      MfRead = 1'b0;
      issue(MULTU, 32'd5, 32'd6, 1'b1, 32'h0, 32'h1E, 1'b0);
      wait_done("back_to_back", 33);
      old_hi = 32'h0;
      old_lo = 32'h1E;

      // abort mid-calc: no Done, Hi/Lo untouched
      repeat (2) @(negedge Clk);
      issue(DIVU, 32'd1000, 32'd3, 1'b0, '0, '0, 1'b0);
      repeat (10) begin @(posedge Clk); #1; end
      Abort = 1'b1;
      @(posedge Clk); #1;
      Abort = 1'b0;
      check("abort_busy", Busy, 0);
      check("abort_hi", Hi, old_hi);
      check("abort_lo", Lo, old_lo);
      done_n = 0;
      repeat (40) begin
         @(posedge Clk); #1;
         if (Done) done_n++;
      end
      check("abort_no_done", done_n, 0);

      // asynchronous reset mid-operation
      issue(MULT, 32'd3, 32'd3, 1'b0, '0, '0, 1'b0);
      repeat (20) begin @(posedge Clk); #1; end
      Rst = 1'b0;
      #1;
      check("rst_mid_hi", Hi, 0);
      check("rst_mid_lo", Lo, 0);
      check("rst_mid_busy", Busy, 0);
      @(negedge Clk);
      Rst = 1'b1;
      run("after_reset", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);

      repeat (3) @(negedge Clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with its sequencing FSM, owning the HI/LO registers for MULT, MULTU, DIV and DIVU.
- Sits beside the EX stage. The decoder supplies a start pulse, an opcode and both register operands.
- The block runs a 32-step shift-add multiply or restoring divide, then applies sign correction.
- It drives a pipeline Stall whenever a dependent MFHI/MFLO or a second mult/div would see stale HI/LO.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request from EX, sampled in IDLE or DONE.
- Op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
- A  input  WIDTH  rs operand (multiplicand or dividend).
- B  input  WIDTH  rt operand (multiplier or divisor).
- MfRead  input  1  ID stage holds MFHI/MFLO this cycle.
- Abort  input  1  pipeline flush; cancels the operation in flight.
- Hi  output  WIDTH  HI register (product upper half or remainder).
- Lo  output  WIDTH  LO register (product lower half or quotient).
- Busy  output  1  high in CALC and FIX.
- Done  output  1  one-cycle pulse in DONE.
- DivByZero  output  1  one-cycle pulse coincident with Done for a zero-divisor divide.
- Stall  output  1  combinational: Busy & (MfRead | Start).

Behaviour:
- Reset (Rst=0, asynchronous):
  - state=IDLE; Hi=0, Lo=0; Busy=0, Done=0, DivByZero=0.
  - Iteration counter and internal operand, accumulator and sign-flag registers are cleared.
  - Reset mid-operation discards the work; Hi/Lo read 0 afterwards.
- States and transitions:
  - IDLE->CALC on Start. The edge that accepts Start is E0.
  - CALC->FIX on the edge where count==WIDTH-1; count is 0 at entry.
  - FIX->DONE on the next edge.
  - DONE->IDLE, or DONE->CALC if Start is high.
- Latency:
  - CALC spans E0..E0+31; FIX is entered at E0+32.
  - Hi/Lo are written at E0+33, entering DONE; Done=1 for the cycle E0+33..E0+34.
  - Busy=1 from E0 until E0+33.
- Operand capture at E0:
  - Signed ops (MULT, DIV) latch |A| and |B|.
  - Record negP = A[31]^B[31] and negR = A[31].
  - Unsigned ops latch the raw operands; both flags = 0.
- Multiply: 64-bit accumulator, shift-add one multiplier bit per CALC cycle, LSB first.
- Divide: restoring algorithm, one quotient bit per CALC cycle, MSB first. Remainder is WIDTH+1 bits internally.
- FIX step:
  - Multiply: product is two's-complement negated across all 64 bits if negP.
  - Divide: quotient is negated if negP; remainder is negated if negR (remainder takes the dividend's sign).
  - Result: {Hi,Lo} = product for multiply; Hi = remainder, Lo = quotient for divide.
- Corner case: DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0 by natural wrap. No trap.
- Divide by zero (Op[1]=1, B=0 at Start):
  - IDLE->FIX at E0, skipping CALC; DONE at E0+1.
  - Hi=A, Lo=all-ones; DivByZero pulses with Done.
- Hi/Lo change only on entry to DONE. They hold otherwise, including during CALC, so old values stay visible while Busy.
- Start while Busy is ignored by the FSM; Stall holds EX until DONE, where the Start is accepted.
- MfRead during DONE or IDLE produces no stall: Hi/Lo are already final.
- Abort:
  - Any state goes to IDLE on the next edge; Abort wins over Start the same cycle.
  - Hi/Lo are unchanged and Done does not pulse.
  - Abort in DONE does not undo the Hi/Lo write already made.
- Op is sampled only at E0; later changes on Op/A/B are ignored.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Done at E0+33; Hi=0xFFFFFFFE, Lo=0x00000001; Busy high exactly 33 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIVU A=100, B=7 -> Lo=14, Hi=2.
- DIV A=0x1234, B=0 -> Done and DivByZero at E0+1; Hi=0x1234, Lo=0xFFFFFFFF.
- MULT started, MfRead=1 at E0+5 -> Stall=1 through E0+32, Stall=0 in DONE, Hi/Lo hold old values until E0+33. Back-to-back Start asserted in DONE begins a new op with no idle cycle.
- Abort at E0+10 -> IDLE at E0+11, no Done, Hi/Lo unchanged. Rst low at E0+20 -> immediate IDLE with Hi=Lo=0.
